scan_scheduler: RTL and testbench
=================================

SCAN_SCHEDULER -- requirements
Module: scan_scheduler

Interface
REQ-001 SHALL use parameters: ROWS, default 16, scanned row pairs; PLANES, default 4, BCM bit-planes per row; BASE_TICKS, default 8, display clocks for plane 0; TIMEOUT, default 1024, max clocks to wait for shifter done.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: CLK_I  in  1  clock, all logic on rising edge; RST_I  in  1  asynchronous active-high reset.
REQ-003 SHALL have port EN_I  in  1  run enable.
REQ-004 SHALL have port SHIFT_START_O  out  1  one-cycle pulse telling the shifter to load a row/plane.
REQ-005 SHALL have port SHIFT_ROW_O  out  log2(ROWS)  row the shifter is to fetch.
REQ-006 SHALL have port SHIFT_PLANE_O  out  log2(PLANES)  plane the shifter is to fetch.
REQ-007 SHALL have port SHIFT_DONE_I  in  1  shifter finished clocking the row out.
REQ-008 SHALL have port LATCH_O  out  1  panel latch, active high.
REQ-009 SHALL have port OE_O  out  1  panel output enable, active low.
REQ-010 SHALL have port ROW_O  out  log2(ROWS)  demux address (RA..RD) of the displayed row.
REQ-011 SHALL have port FRAME_O  out  1  one-cycle end-of-frame pulse.
REQ-012 SHALL have port ERR_O  out  1  sticky shifter-timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, BLANK, LATCH, DISPLAY; all outputs registered.
REQ-014 IDLE: OE_O=1, LATCH_O=0; on EN_I=1 and ERR_O=0 -> SHIFT.
REQ-015 SHIFT_START_O SHALL be high exactly in the first SHIFT cycle, with SHIFT_ROW_O/SHIFT_PLANE_O valid and held stable until LATCH exits.
REQ-016 SHIFT: SHIFT_DONE_I sampled from the second SHIFT cycle; done high -> BLANK; done in the start cycle ignored.
REQ-017 SHIFT: wait counter reaching TIMEOUT without done -> set ERR_O, -> IDLE, row/plane counters unchanged.
REQ-018 BLANK: exactly 1 cycle, OE_O=1 -> LATCH.
REQ-019 LATCH: exactly 1 cycle, LATCH_O=1, OE_O=1; ROW_O loads SHIFT_ROW_O this cycle -> DISPLAY.
REQ-020 DISPLAY: OE_O=0 for exactly BASE_TICKS<<plane cycles; timer width = log2(BASE_TICKS<<(PLANES-1))+1 bits, no overflow.
REQ-021 Scan order SHALL be plane inner (0..PLANES-1), row outer (0..ROWS-1); both wrap to 0 after last value.
REQ-022 At DISPLAY exit: advance plane/row; if row=ROWS-1 and plane=PLANES-1, FRAME_O=1 for that cycle.
REQ-023 DISPLAY exit with EN_I=1 -> SHIFT; EN_I=0 -> IDLE, position retained; EN_I drop mid-plane SHALL NOT truncate DISPLAY.
REQ-024 OE_O SHALL never be 0 in any state other than DISPLAY; LATCH_O and OE_O=0 never simultaneous.
REQ-025 ERR_O SHALL clear only on reset.

Reset
REQ-026 RST_I asserted at any time: state=IDLE, row=0, plane=0, ROW_O=0, OE_O=1, LATCH_O=0, SHIFT_START_O=0, FRAME_O=0, ERR_O=0, timers=0; takes effect without clock.
REQ-027 After RST_I release, first SHIFT_START_O no earlier than the second rising edge with EN_I=1.

Structure
REQ-028 Shared package led_pkg SHALL hold the state enumeration, ROWS/PLANES defaults, and address/plane width constants.
REQ-029 DISPLAY timer and TIMEOUT counter SHALL share one sub-module, scan_timer (loadable down-counter with zero flag).

Verification
REQ-030 Defaults, EN_I=1, done 40 cycles after each start -> OE_O low runs 8,16,32,64 cycles for row 0, then SHIFT_ROW_O=1, plane 0.
REQ-031 Full frame -> 64 start pulses, FRAME_O single pulse after row 15 plane 3 display, next start row 0 plane 0.
REQ-032 Done never asserted -> ERR_O=1 after 1024 wait cycles, OE_O stays 1, no further starts until reset.
REQ-033 EN_I low 5 cycles into plane 2 display -> OE_O low full 32 cycles, then IDLE; re-enable -> start at plane 3, same row.
REQ-034 RST_I pulse mid-DISPLAY -> OE_O=1 and ROW_O=0 immediately; restart at row 0 plane 0.
REQ-035 Done asserted in start cycle only -> ignored, FSM stays SHIFT until a later done.

Source files
------------

// File: rtl/led_pkg.sv
// Types and constants shared by the LED panel scan scheduler, its interface and its timer.
package led_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

    localparam int DEF_ROWS       = 16;
    localparam int DEF_PLANES     = 4;
    localparam int DEF_BASE_TICKS = 8;
    localparam int DEF_TIMEOUT    = 1024;

    // Index width with a floor of one bit so single-entry configurations still elaborate.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DEF_ROW_W   = addr_width(DEF_ROWS);
    localparam int DEF_PLANE_W = addr_width(DEF_PLANES);
endpackage

// File: rtl/scan_scheduler_if.sv
// Shifter handshake and panel control signals of the scan scheduler.
interface scan_scheduler_if
    import led_pkg::*;
#(
    parameter int ROW_W   = DEF_ROW_W,
    parameter int PLANE_W = DEF_PLANE_W
);
    logic               EN_I;
    logic               SHIFT_START_O;
    logic [ROW_W-1:0]   SHIFT_ROW_O;
    logic [PLANE_W-1:0] SHIFT_PLANE_O;
    logic               SHIFT_DONE_I;
    logic               LATCH_O;
    logic               OE_O;
    logic [ROW_W-1:0]   ROW_O;
    logic               FRAME_O;
    logic               ERR_O;

    modport master (
        input  EN_I, SHIFT_DONE_I,
        output SHIFT_START_O, SHIFT_ROW_O, SHIFT_PLANE_O, LATCH_O, OE_O, ROW_O, FRAME_O, ERR_O
    );

    modport slave (
        output EN_I, SHIFT_DONE_I,
        input  SHIFT_START_O, SHIFT_ROW_O, SHIFT_PLANE_O, LATCH_O, OE_O, ROW_O, FRAME_O, ERR_O
    );
endinterface

// File: rtl/scan_timer.sv
// Loadable down-counter that stops at zero; serves both the shift timeout and the display time.
module scan_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);
endmodule

// File: rtl/scan_scheduler.sv
// Binary-code-modulation scan scheduler for a HUB75-style LED panel: shift a row/plane,
// blank, latch, then light it for BASE_TICKS<<plane clocks.
module scan_scheduler
    import led_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int PLANES     = DEF_PLANES,
    parameter int BASE_TICKS = DEF_BASE_TICKS,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic CLK_I,
    input  logic RST_I,
    scan_scheduler_if.master bus
);
    localparam int ROW_W   = addr_width(ROWS);
    localparam int PLANE_W = addr_width(PLANES);
    localparam int DISP_W  = addr_width(BASE_TICKS << (PLANES - 1)) + 1;
    localparam int TW      = max_int(DISP_W, addr_width(TIMEOUT) + 1);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [PLANE_W-1:0] plane_reg, plane_next;
    logic               err_reg, err_next;
    logic               frame_next;
    logic               start_reg, latch_reg, oe_reg, frame_reg, armed_reg;
    logic [ROW_W-1:0]   row_out_reg;
    logic               tmr_load, tmr_zero;
    logic [TW-1:0]      tmr_value;

    scan_timer #(.W(TW)) u_timer (
        .clk   (CLK_I),
        .rst   (RST_I),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        plane_next = plane_reg;
        err_next   = err_reg;
        frame_next = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        case (state_reg)
            IDLE: begin
                // armed_reg keeps the first edge after reset release from starting a shift
                if (bus.EN_I && !err_reg && armed_reg) begin
                    state_next = SHIFT;
                    tmr_load   = 1'b1;
                    tmr_value  = WAIT_LOAD;
                end
            end
            SHIFT: begin
                // start_reg marks the start cycle, where a done is stale and ignored
                if (!start_reg && bus.SHIFT_DONE_I) begin
                    state_next = BLANK;
                end else if (tmr_zero) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
            BLANK: state_next = LATCH;
            LATCH: begin
                state_next = DISPLAY;
                tmr_load   = 1'b1;
                tmr_value  = (TW'(BASE_TICKS) << plane_reg) - TW'(1);
            end
            DISPLAY: begin
                if (tmr_zero) begin
                    if (plane_reg == PLANE_W'(PLANES - 1)) begin
                        plane_next = '0;
                        if (row_reg == ROW_W'(ROWS - 1)) begin
                            row_next   = '0;
                            frame_next = 1'b1;
                        end else begin
                            row_next = row_reg + 1'b1;
                        end
                    end else begin
                        plane_next = plane_reg + 1'b1;
                    end
                    if (bus.EN_I) begin
                        state_next = SHIFT;
                        tmr_load   = 1'b1;
                        tmr_value  = WAIT_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_reg   <= IDLE;
            row_reg     <= '0;
            plane_reg   <= '0;
            err_reg     <= 1'b0;
            frame_reg   <= 1'b0;
            start_reg   <= 1'b0;
            latch_reg   <= 1'b0;
            oe_reg      <= 1'b1;
            armed_reg   <= 1'b0;
            row_out_reg <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            plane_reg <= plane_next;
            err_reg   <= err_next;
            frame_reg <= frame_next;
            armed_reg <= 1'b1;
            // Outputs are decoded from the next state so they line up with state_reg.
            start_reg <= (state_next == SHIFT) && (state_reg != SHIFT);
            latch_reg <= (state_next == LATCH);
            oe_reg    <= (state_next != DISPLAY);
            if (state_next == LATCH) begin
                row_out_reg <= row_reg;
            end
        end
    end

    assign bus.SHIFT_START_O = start_reg;
    assign bus.SHIFT_ROW_O   = row_reg;
    assign bus.SHIFT_PLANE_O = plane_reg;
    assign bus.LATCH_O       = latch_reg;
    assign bus.OE_O          = oe_reg;
    assign bus.ROW_O         = row_out_reg;
    assign bus.FRAME_O       = frame_reg;
    assign bus.ERR_O         = err_reg;
endmodule

// File: tb/tb_scan_scheduler.sv
// Self-checking bench for scan_scheduler: random shifter latency against a slot-index model.
module tb_scan_scheduler;
    import led_pkg::*;

    localparam int ROWS    = DEF_ROWS;
    localparam int PLANES  = DEF_PLANES;
    localparam int BASE    = DEF_BASE_TICKS;
    localparam int TIMEOUT = DEF_TIMEOUT;
    localparam int SLOTS   = ROWS * PLANES;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    scan_scheduler_if #(.ROW_W(DEF_ROW_W), .PLANE_W(DEF_PLANE_W)) bus ();

    scan_scheduler #(
        .ROWS(ROWS), .PLANES(PLANES), .BASE_TICKS(BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observations gathered on the falling edge
    int start_cnt, latch_cnt, viol_cnt, total_viol;
    int q_srow[$], q_splane[$], q_run_len[$], q_run_row[$], q_frame_at[$];
    int run_len, run_row;
    bit oe_prev, latch_prev;
    bit resp_on;
    int resp_min, resp_max;

    // Slot-index model: slot n shows row (n/PLANES)%ROWS, plane n%PLANES, for BASE<<plane clocks.
    function automatic int exp_row(input int n);
        return (n / PLANES) % ROWS;
    endfunction
    function automatic int exp_plane(input int n);
        return n % PLANES;
    endfunction
    function automatic int exp_len(input int n);
        return BASE << (n % PLANES);
    endfunction

    task automatic clear_obs();
        start_cnt = 0; latch_cnt = 0; viol_cnt = 0;
        q_srow.delete(); q_splane.delete(); q_run_len.delete();
        q_run_row.delete(); q_frame_at.delete();
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                oe_prev = 1'b1; latch_prev = 1'b0; run_len = 0;
            end else begin
                if (bus.SHIFT_START_O) begin
                    start_cnt++;
                    q_srow.push_back(int'(bus.SHIFT_ROW_O));
                    q_splane.push_back(int'(bus.SHIFT_PLANE_O));
                end
                if (bus.LATCH_O) latch_cnt++;
                if (bus.LATCH_O && !bus.OE_O) begin viol_cnt++; total_viol++; end
                if (!bus.OE_O) begin
                    if (oe_prev) begin
                        run_len = 0;
                        run_row = int'(bus.ROW_O);
                        if (!latch_prev) begin viol_cnt++; total_viol++; end
                    end
                    run_len++;
                    if (int'(bus.ROW_O) != run_row) begin viol_cnt++; total_viol++; end
                end else if (!oe_prev) begin
                    q_run_len.push_back(run_len);
                    q_run_row.push_back(run_row);
                end
                if (bus.FRAME_O) q_frame_at.push_back(q_run_len.size());
                oe_prev    = bus.OE_O;
                latch_prev = bus.LATCH_O;
            end
        end
    endtask

    // Shifter model: answers each start with a one-cycle done after a random latency.
    task automatic responder();
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (resp_on && !rst) begin
                bus.SHIFT_DONE_I = 1'b0;
                if (bus.SHIFT_START_O) begin
                    cnt = $urandom_range(resp_max, resp_min);
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) bus.SHIFT_DONE_I = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    endtask

    task automatic apply_reset();
        bus.EN_I = 1'b0; bus.SHIFT_DONE_I = 1'b0; resp_on = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        clear_obs();
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        int k = 0;
        while (start_cnt < n && k < budget) begin @(posedge clk); k++; end
        #1 ok = (start_cnt >= n);
    endtask

    task automatic wait_runs(input int n, input int budget, output bit ok);
        int k = 0;
        while (q_run_len.size() < n && k < budget) begin @(posedge clk); k++; end
        #1 ok = (q_run_len.size() >= n);
    endtask

    task automatic wait_display(input int slot, input int budget, output bit ok);
        int k = 0;
        do begin @(negedge clk); k++; end
        while (!(q_run_len.size() == slot && !bus.OE_O) && k < budget);
        ok = (q_run_len.size() == slot && !bus.OE_O);
    endtask

    task automatic test_reset();
        bit ok;
        bus.EN_I = 1'b0; bus.SHIFT_DONE_I = 1'b0; resp_on = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_cmp++; if (bus.OE_O !== 1'b1) begin n_err++; $display("FAIL reset_oe got=%b want=1", bus.OE_O); end
        n_cmp++; if (bus.LATCH_O !== 1'b0) begin n_err++; $display("FAIL reset_latch got=%b want=0", bus.LATCH_O); end
        n_cmp++; if (bus.SHIFT_START_O !== 1'b0) begin n_err++; $display("FAIL reset_start got=%b want=0", bus.SHIFT_START_O); end
        n_cmp++; if (bus.FRAME_O !== 1'b0) begin n_err++; $display("FAIL reset_frame got=%b want=0", bus.FRAME_O); end
        n_cmp++; if (bus.ERR_O !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b want=0", bus.ERR_O); end
        n_cmp++; if (bus.ROW_O !== '0) begin n_err++; $display("FAIL reset_row got=%0d want=0", bus.ROW_O); end
        n_cmp++; if (bus.SHIFT_ROW_O !== '0) begin n_err++; $display("FAIL reset_shift_row got=%0d want=0", bus.SHIFT_ROW_O); end
        n_cmp++; if (bus.SHIFT_PLANE_O !== '0) begin n_err++; $display("FAIL reset_shift_plane got=%0d want=0", bus.SHIFT_PLANE_O); end
        @(posedge clk);
        #2 rst = 1'b0;
        clear_obs();
        resp_min = 2; resp_max = 10; resp_on = 1'b1;
        bus.EN_I = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.SHIFT_START_O !== 1'b0) begin n_err++; $display("FAIL first_edge_start got=%b want=0", bus.SHIFT_START_O); end
        wait_starts(1, 4, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL first_start_seen got=%0d want=1", start_cnt); end
        if (ok) begin
            n_cmp++; if (q_srow[0] != 0 || q_splane[0] != 0) begin
                n_err++; $display("FAIL first_start_pos got=r%0d/p%0d want=r0/p0", q_srow[0], q_splane[0]);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_row0_planes();
        bit ok;
        apply_reset();
        resp_min = 40; resp_max = 40; resp_on = 1'b1;
        bus.EN_I = 1'b1;
        wait_starts(5, 3000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL row0_progress got=%0d want=5 starts", start_cnt); end
        if (ok) begin
            for (int i = 0; i < PLANES; i++) begin
                n_cmp++; if (q_run_len[i] != (BASE << i)) begin
                    n_err++; $display("FAIL row0_oe_run plane=%0d got=%0d want=%0d", i, q_run_len[i], BASE << i);
                end
                n_cmp++; if (q_run_row[i] != 0) begin
                    n_err++; $display("FAIL row0_row_o plane=%0d got=%0d want=0", i, q_run_row[i]);
                end
                $display("row0 plane %0d: oe low %0d cycles", i, q_run_len[i]);
            end
            n_cmp++; if (q_srow[4] != 1 || q_splane[4] != 0) begin
                n_err++; $display("FAIL row1_start got=r%0d/p%0d want=r1/p0", q_srow[4], q_splane[4]);
            end
        end
    endtask

    task automatic test_full_frame();
        bit ok;
        apply_reset();
        resp_min = 1; resp_max = 50; resp_on = 1'b1;
        bus.EN_I = 1'b1;
        wait_starts(SLOTS + 1, 20000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL frame_progress got=%0d want=%0d starts", start_cnt, SLOTS + 1); end
        if (ok) begin
            for (int n = 0; n < SLOTS; n++) begin
                $display("slot %0d: start r%0d p%0d, oe low %0d on row %0d",
                         n, q_srow[n], q_splane[n], q_run_len[n], q_run_row[n]);
                n_cmp++; if (q_srow[n] != exp_row(n) || q_splane[n] != exp_plane(n)) begin
                    n_err++; $display("FAIL frame_start slot=%0d got=r%0d/p%0d want=r%0d/p%0d",
                                      n, q_srow[n], q_splane[n], exp_row(n), exp_plane(n));
                end
                n_cmp++; if (q_run_len[n] != exp_len(n) || q_run_row[n] != exp_row(n)) begin
                    n_err++; $display("FAIL frame_display slot=%0d got=%0d@r%0d want=%0d@r%0d",
                                      n, q_run_len[n], q_run_row[n], exp_len(n), exp_row(n));
                end
            end
            n_cmp++; if (q_srow[SLOTS] != 0 || q_splane[SLOTS] != 0) begin
                n_err++; $display("FAIL frame_wrap got=r%0d/p%0d want=r0/p0", q_srow[SLOTS], q_splane[SLOTS]);
            end
            n_cmp++; if (q_frame_at.size() != 1) begin
                n_err++; $display("FAIL frame_pulse_count got=%0d want=1", q_frame_at.size());
            end else begin
                n_cmp++; if (q_frame_at[0] != SLOTS) begin
                    n_err++; $display("FAIL frame_pulse_pos got=after slot %0d want=after slot %0d", q_frame_at[0], SLOTS);
                end
            end
            n_cmp++; if (viol_cnt != 0) begin n_err++; $display("FAIL frame_oe_rules got=%0d violations want=0", viol_cnt); end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int s;
        apply_reset();
        resp_min = 1; resp_max = 30; resp_on = 1'b1;
        s = $urandom_range(2 * PLANES + 2, 1);
        bus.EN_I = 1'b1;
        wait_display(s, 10000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL endrop_reach got=%0d runs want=slot %0d", q_run_len.size(), s); end
        if (ok) begin
            repeat (5) @(posedge clk);
            #1 bus.EN_I = 1'b0;
            wait_runs(s + 1, 200, ok);
            n_cmp++; if (!ok || q_run_len[s] != exp_len(s)) begin
                n_err++; $display("FAIL endrop_full_run slot=%0d got=%0d want=%0d", s, ok ? q_run_len[s] : -1, exp_len(s));
            end
            repeat (40) @(posedge clk);
            #1;
            n_cmp++; if (start_cnt != s + 1 || bus.OE_O !== 1'b1) begin
                n_err++; $display("FAIL endrop_idle got=%0d starts oe=%b want=%0d starts oe=1", start_cnt, bus.OE_O, s + 1);
            end
            bus.EN_I = 1'b1;
            wait_starts(s + 2, 10, ok);
            n_cmp++; if (!ok || q_srow[s + 1] != exp_row(s + 1) || q_splane[s + 1] != exp_plane(s + 1)) begin
                n_err++; $display("FAIL endrop_resume got=%0d starts want=r%0d/p%0d", start_cnt, exp_row(s + 1), exp_plane(s + 1));
            end
            $display("enable drop in slot %0d: run %0d, resumed", s, q_run_len[s]);
        end
    endtask

    task automatic test_done_in_start();
        bit ok;
        int k = 0;
        apply_reset();
        bus.EN_I = 1'b1;
        do begin @(negedge clk); k++; end while (!bus.SHIFT_START_O && k < 10);
        n_cmp++; if (!bus.SHIFT_START_O) begin n_err++; $display("FAIL dstart_start got=0 want=1"); end
        bus.SHIFT_DONE_I = 1'b1;
        @(negedge clk);
        bus.SHIFT_DONE_I = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++; if (latch_cnt != 0 || bus.OE_O !== 1'b1 || start_cnt != 1) begin
            n_err++; $display("FAIL dstart_ignored got=latch %0d oe %b starts %0d want=0/1/1", latch_cnt, bus.OE_O, start_cnt);
        end
        @(negedge clk);
        bus.SHIFT_DONE_I = 1'b1;
        @(negedge clk);
        bus.SHIFT_DONE_I = 1'b0;
        wait_runs(1, 40, ok);
        n_cmp++; if (!ok || latch_cnt != 1 || q_run_len[0] != exp_len(0)) begin
            n_err++; $display("FAIL dstart_later_done got=latch %0d runs %0d want=1/1 of %0d", latch_cnt, q_run_len.size(), exp_len(0));
        end
        $display("done-in-start ignored, later done accepted");
    endtask

    task automatic test_reset_mid_display();
        bit ok;
        int k;
        apply_reset();
        resp_min = 1; resp_max = 20; resp_on = 1'b1;
        k = $urandom_range(3 * PLANES - 1, PLANES);
        bus.EN_I = 1'b1;
        wait_display(k, 10000, ok);
        n_cmp++; if (!ok || bus.ROW_O !== DEF_ROW_W'(exp_row(k))) begin
            n_err++; $display("FAIL rstmid_pre got=row %0d want=row %0d", bus.ROW_O, exp_row(k));
        end
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (bus.OE_O !== 1'b1 || bus.ROW_O !== '0 || bus.LATCH_O !== 1'b0) begin
            n_err++; $display("FAIL rstmid_async got=oe %b row %0d latch %b want=1/0/0", bus.OE_O, bus.ROW_O, bus.LATCH_O);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        clear_obs();
        wait_starts(1, 10, ok);
        n_cmp++; if (!ok || q_srow[0] != 0 || q_splane[0] != 0) begin
            n_err++; $display("FAIL rstmid_restart got=%0d starts want=r0/p0", start_cnt);
        end
        $display("reset in slot %0d, restart at r0 p0", k);
    endtask

    task automatic test_timeout();
        int k = 0;
        int n = 0;
        int oe_low = 0;
        apply_reset();
        bus.EN_I = 1'b1;
        do begin @(negedge clk); k++; end while (!bus.SHIFT_START_O && k < 10);
        do begin
            @(negedge clk);
            n++;
            if (!bus.OE_O) oe_low++;
        end while (!bus.ERR_O && n < TIMEOUT + 20);
        n_cmp++; if (n != TIMEOUT) begin n_err++; $display("FAIL timeout_cycles got=%0d want=%0d", n, TIMEOUT); end
        n_cmp++; if (oe_low != 0) begin n_err++; $display("FAIL timeout_oe got=%0d low cycles want=0", oe_low); end
        repeat (200) @(posedge clk);
        #1;
        n_cmp++; if (start_cnt != 1 || bus.ERR_O !== 1'b1 || bus.OE_O !== 1'b1 || bus.SHIFT_PLANE_O !== '0) begin
            n_err++; $display("FAIL timeout_sticky got=starts %0d err %b oe %b want=1/1/1", start_cnt, bus.ERR_O, bus.OE_O);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.ERR_O !== 1'b0) begin n_err++; $display("FAIL timeout_clear got=%b want=0", bus.ERR_O); end
        @(posedge clk);
        #2 rst = 1'b0;
        $display("timeout after %0d cycles", n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.EN_I = 1'b0;
        bus.SHIFT_DONE_I = 1'b0;
        resp_on = 1'b0; resp_min = 1; resp_max = 1;
        total_viol = 0;
        oe_prev = 1'b1; latch_prev = 1'b0; run_len = 0; run_row = 0;
        clear_obs();
        fork
            monitor();
            responder();
        join_none
        test_reset();
        test_row0_planes();
        test_full_frame();
        test_enable_drop();
        test_done_in_start();
        test_reset_mid_display();
        test_timeout();
        n_cmp++; if (total_viol != 0) begin n_err++; $display("FAIL oe_latch_rules got=%0d want=0", total_viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
